// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants (RX state encoding, parity modes, frame sizes).
package uart_pkg;
   localparam int UART_DATA_W     = 8;
   localparam int UART_FRAME_BITS = 11;
   localparam int PARITY_EVEN     = 0;
   localparam int PARITY_ODD      = 1;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_e;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input plus received-byte/status bundle of the UART receiver.
interface uart_rx_if;
   import uart_pkg::*;
   logic                   rx;
   logic [UART_DATA_W-1:0] data_rx;
   logic                   rx_valid;
   logic                   parity_err;
   logic                   frame_err;
   logic                   rx_busy;
   modport slave  (input rx, output data_rx, rx_valid, parity_err, frame_err, rx_busy);
   modport master (output rx, input data_rx, rx_valid, parity_err, frame_err, rx_busy);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser for an asynchronous input with a configurable reset value.
module uart_rx_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);
   logic [1:0] ff_q;
   always_ff @(posedge clk)
      ff_q <= reset ? {2{RST_VAL}} : {ff_q[0], d_i};
   assign q_o = ff_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver (start, 8 data LSB-first, parity, stop) on the system clock.
// Define UART_RX_PARITY_CHECK_EN to report parity mismatches; otherwise parity_err stays 0.
`ifndef BAUD8M
`define BAUD8M 16
`endif
module uart_rx
   import uart_pkg::*;
#(
   parameter int BAUD_RATE = `BAUD8M,
   parameter int PARITY    = PARITY_EVEN
) (
   input logic      clk,
   input logic      reset,
   uart_rx_if.slave bus
);
`ifdef UART_RX_PARITY_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif
   localparam int            CW   = $clog2(BAUD_RATE);
   localparam logic [CW-1:0] HALF = CW'(BAUD_RATE / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(BAUD_RATE - 1);

   rx_state_e              state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [2:0]             idx_q, idx_d;
   logic [UART_DATA_W-1:0] sh_q, sh_d, data_q, data_d;
   logic                   valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, pbad_q, pbad_d;
   logic                   rx_s, rx_d_q, tick, exp_par;

   uart_rx_sync #(.RST_VAL(1'b1)) u_sync (.clk(clk), .reset(reset), .d_i(bus.rx), .q_o(rx_s));

   assign tick    = cnt_q == '0;
   assign exp_par = (PARITY == PARITY_ODD) ? ~^sh_q : ^sh_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         pbad_q  <= 1'b0;
         rx_d_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         pbad_q  <= pbad_d;
         rx_d_q  <= rx_s;
      end
   end

   // The bit counter free-runs between expiries; only START entry loads the half period.
   always_comb begin
      state_d = state_q;
      cnt_d   = tick ? FULL : cnt_q - CW'(1);
      idx_d   = idx_q;
      sh_d    = sh_q;
      data_d  = data_q;
      valid_d = 1'b0;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      pbad_d  = pbad_q;
      case (state_q)
         RX_IDLE: begin
            idx_d = '0;
            if (rx_d_q && !rx_s) begin
               cnt_d   = HALF;
               state_d = RX_START;
            end
         end
         RX_START:  if (tick) state_d = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA: if (tick) begin
            sh_d    = {rx_s, sh_q[UART_DATA_W-1:1]};
            idx_d   = idx_q + 3'd1;
            state_d = (idx_q == 3'd7) ? RX_PARITY : RX_DATA;
         end
         RX_PARITY: if (tick) begin
            pbad_d  = rx_s ^ exp_par;
            state_d = RX_STOP;
         end
         RX_STOP: if (tick) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            perr_d  = CHK & pbad_q;
            ferr_d  = !rx_s;
            state_d = rx_s ? RX_IDLE : RX_BREAK;
         end
         RX_BREAK:  if (rx_s) state_d = RX_IDLE;
         default:   state_d = RX_IDLE;
      endcase
   end

   assign bus.data_rx    = data_q;
   assign bus.rx_valid   = valid_q;
   assign bus.parity_err = perr_q;
   assign bus.frame_err  = ferr_q;
   assign bus.rx_busy    = state_q != RX_IDLE;
endmodule
